aes_cop_ctrl: RTL
=================

Name: aes_cop_ctrl

Overview:
- Sequencer for the custom-0 AES instructions (AES-ENC funct7=0000000, AES-DEC funct7=0000001, opcode 0001011, funct3=000).
- Sits beside the RV32 core's decode stage and stalls the pipeline while it runs.
- Gathers 128-bit key (rs1..rs1+3) and block (rs2..rs2+3) over a single regfile read port, then starts the iterative AES core.
- Writes the 128-bit result to rd..rd+3 over a single regfile write port.

Parameters:
- XLEN, 32, register width; fixed at 32.
- REG_AW, 5, regfile address width.
- WB_X0_GUARD, 1, when 1, writes that target x0 are suppressed.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  decode holds a valid instruction.
- instr  in  32  instruction word from decode.
- stall  out  1  freeze fetch/decode/PC.
- rf_raddr  out  5  regfile read address (combinational read).
- rf_rdata  in  32  regfile read data, same cycle.
- rf_we  out  1  regfile write enable.
- rf_waddr  out  5  write address.
- rf_wdata  out  32  write data.
- aes_start  out  1  one-cycle start pulse to the AES core.
- aes_decrypt  out  1  0=encrypt, 1=decrypt; held stable from START until done.
- aes_key  out  128  latched key.
- aes_din  out  128  latched block.
- aes_done  in  1  one-cycle pulse from the core.
- aes_dout  in  128  core result, valid when aes_done=1.
- op_done  out  1  one-cycle pulse when the final word is written.
- illegal  out  1  one-cycle pulse for custom-0 with an unsupported funct3 or funct7.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; key, block and result registers cleared. Reset mid-operation aborts immediately and performs no further writes.
- Recognition: is_aes = instr_valid & opcode==0001011 & funct3==000 & funct7 in {0,1}.
- Stall: stall = (state!=IDLE && state!=DONE) | (state==IDLE & is_aes). Stall is combinational so the issuing instruction is held in decode.
- States:
  - IDLE: on is_aes, latch rd/rs1/rs2/funct7[0], cnt=0, go to RD_KEY. Custom-0 with a bad funct3/funct7 pulses illegal for one cycle, no stall, stays IDLE.
  - RD_KEY: rf_raddr = (rs1+cnt) mod 32. Capture word cnt; word 0 goes to bits [127:96]. After cnt=3, go to RD_DAT with cnt=0.
  - RD_DAT: same scheme using rs2 into aes_din. After 4 words, go to START.
  - START: aes_start=1 for one cycle, go to WAIT.
  - WAIT: on aes_done, latch aes_dout and go to WB with cnt=0. No timeout.
  - WB: rf_we=1, rf_waddr=(rd+cnt) mod 32, rf_wdata = result word cnt (word 0 = [127:96]). Four cycles. When waddr==0 and WB_X0_GUARD=1, rf_we=0 but the slot is still consumed. Go to DONE.
  - DONE: op_done=1, stall=0 so the pipeline retires the instruction. Return to IDLE. is_aes is ignored in this cycle, because the retiring instruction is still in decode.
- Operand reads occur before any writeback, so rd overlapping rs1/rs2 is safe.
- Register index wrap (e.g. rs1=30 reads 30,31,0,1) is required behaviour.
- Latency: issue cycle + 4 + 4 + 1 + core latency L + 4 + 1 = 15+L cycles of stall.
- aes_done arriving outside WAIT is ignored.

Optional Feature:
- Macro AES_COP_PERF_EN.
- When defined, adds output perf_ops[31:0], counting op_done pulses, and output perf_cycles[31:0], counting cycles with state!=IDLE. Both wrap at 2^32 and reset to 0.
- When undefined, neither port nor the counters exist.

Decomposition:
- Package aes_cop_pkg holds:
  - opcode constant OPC_CUSTOM0=7'b0001011.
  - F7_ENC=7'h00, F7_DEC=7'h01.
  - state enum {IDLE, RD_KEY, RD_DAT, START, WAIT, WB, DONE}.
  - Word-select helper function.
- One natural sub-module: aes_cop_wordseq, the 2-bit counter plus base+cnt mod-32 address generator. It is shared by the read and write phases.

Test Plan:
- ENC, FIPS-197 vector: x14..x17=00010203_04050607_08090a0b_0c0d0e0f, x10..x13=00112233_44556677_8899aabb_ccddeeff, instr 00a7090b, stub core L=10.
  - Expect x18..x21=69c4e0d8_6a7b0430_d8cdb780_70b4c55a.
  - Expect stall high for exactly 25 cycles, then a single op_done pulse.
- DEC, instr 03270b0b after the above: x22..x25 = plaintext 00112233.. and aes_decrypt=1 through WAIT.
- Wrap/x0: rs1=30, rd=30 → reads 30,31,0,1; writes 30,31 and 1; no write to x0 (rf_we=0 in the third WB slot).
- Illegal: funct7=0000010, opcode 0001011 → illegal pulses once, stall never rises, no aes_start.
- Reset abort: deassert rst_n during WB cnt=1 → outputs 0 immediately, no further rf_we; a fresh ENC after reset completes normally.
- Spurious aes_done in RD_DAT is ignored; the result comes only from the done pulse received in WAIT.

Source files
------------

// File: rtl/aes_cop_pkg.sv
// Shared definitions for the custom-0 AES coprocessor sequencer:
// opcode/funct constants, the sequencer state encoding and 32-bit word
// helpers for the 128-bit key/block/result registers (word 0 = [127:96]).
package aes_cop_pkg;

  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
  localparam logic [6:0] F7_ENC      = 7'h00;
  localparam logic [6:0] F7_DEC      = 7'h01;
  localparam logic [2:0] F3_AES      = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    RD_KEY,
    RD_DAT,
    START,
    WAIT,
    WB,
    DONE
  } state_t;

  function automatic logic [31:0] word_get(input logic [127:0] v, input logic [1:0] idx);
    case (idx)
      2'd0:    return v[127:96];
      2'd1:    return v[95:64];
      2'd2:    return v[63:32];
      default: return v[31:0];
    endcase
  endfunction

  function automatic logic [127:0] word_put(input logic [127:0] v, input logic [1:0] idx,
                                            input logic [31:0] w);
    logic [127:0] r;
    r = v;
    case (idx)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_cop_wordseq.sv
// Word sequencer: 2-bit word counter plus (base + cnt) mod 2^AW register
// address. Counts while run is high and parks at 0 otherwise, so each
// four-word phase starts from word 0 and naturally wraps into the next.
module aes_cop_wordseq #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic [AW-1:0] base,
  output logic [1:0]    cnt,
  output logic [AW-1:0] addr,
  output logic          last
);

  // Word counter: advance during a transfer phase, hold at 0 between phases
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= 2'd0;
    else if (run) cnt <= cnt + 2'd1;
    else          cnt <= 2'd0;
  end

  assign addr = base + AW'(cnt);
  assign last = (cnt == 2'd3);

endmodule

// File: rtl/aes_cop_ctrl.sv
// Sequencer for the custom-0 AES-ENC/AES-DEC instructions. Stalls decode,
// gathers key (rs1..rs1+3) and block (rs2..rs2+3) over one read port, runs
// the iterative core, then writes rd..rd+3 over one write port.
// Optional build macro AES_COP_PERF_EN adds perf_ops/perf_cycles counters.
module aes_cop_ctrl
  import aes_cop_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int REG_AW      = 5,
  parameter int WB_X0_GUARD = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              stall,
  output logic [REG_AW-1:0] rf_raddr,
  input  logic [XLEN-1:0]   rf_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              aes_start,
  output logic              aes_decrypt,
  output logic [127:0]      aes_key,
  output logic [127:0]      aes_din,
  input  logic              aes_done,
  input  logic [127:0]      aes_dout,
  output logic              op_done,
  output logic              illegal
`ifdef AES_COP_PERF_EN
  ,
  output logic [31:0]       perf_ops,
  output logic [31:0]       perf_cycles
`endif
);

  state_t            state;
  logic [REG_AW-1:0] rd_q, rs1_q, rs2_q;
  logic [127:0]      result;
  logic              custom0, is_aes;
  logic [6:0]        funct7;
  logic [2:0]        funct3;
  logic              seq_run, seq_last;
  logic [1:0]        seq_cnt;
  logic [REG_AW-1:0] seq_base, seq_addr;

  assign funct7  = instr[31:25];
  assign funct3  = instr[14:12];
  assign custom0 = instr_valid && (instr[6:0] == OPC_CUSTOM0);
  assign is_aes  = custom0 && (funct3 == F3_AES) && ((funct7 == F7_ENC) || (funct7 == F7_DEC));

  // Hold decode while busy; DONE releases it so the instruction retires.
  // rst_n gates the issue term so every output is low while in reset.
  assign stall = ((state != IDLE) && (state != DONE)) ||
                 ((state == IDLE) && is_aes && rst_n);

  assign seq_run  = (state == RD_KEY) || (state == RD_DAT) || (state == WB);
  assign seq_base = (state == RD_KEY) ? rs1_q : (state == RD_DAT) ? rs2_q : rd_q;

  aes_cop_wordseq #(.AW(REG_AW)) u_wordseq (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (seq_run),
    .base  (seq_base),
    .cnt   (seq_cnt),
    .addr  (seq_addr),
    .last  (seq_last)
  );

  assign rf_raddr = ((state == RD_KEY) || (state == RD_DAT)) ? seq_addr : '0;
  assign rf_waddr = (state == WB) ? seq_addr : '0;
  assign rf_wdata = (state == WB) ? XLEN'(word_get(result, seq_cnt)) : '0;
  // An x0 slot still takes its cycle; only the enable is dropped
  assign rf_we    = (state == WB) && !((WB_X0_GUARD != 0) && (seq_addr == '0));

  // Main sequencer: operand capture, core handshake and pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      aes_decrypt <= 1'b0;
      aes_key     <= '0;
      aes_din     <= '0;
      result      <= '0;
      aes_start   <= 1'b0;
      op_done     <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      aes_start <= 1'b0;
      op_done   <= 1'b0;
      illegal   <= 1'b0;
      case (state)
        IDLE: begin
          if (is_aes) begin
            rd_q        <= instr[11:7];
            rs1_q       <= instr[19:15];
            rs2_q       <= instr[24:20];
            aes_decrypt <= funct7[0];
            state       <= RD_KEY;
          end else if (custom0) begin
            illegal <= 1'b1;
          end
        end
        RD_KEY: begin
          aes_key <= word_put(aes_key, seq_cnt, rf_rdata[31:0]);
          if (seq_last) state <= RD_DAT;
        end
        RD_DAT: begin
          aes_din <= word_put(aes_din, seq_cnt, rf_rdata[31:0]);
          if (seq_last) begin
            aes_start <= 1'b1;
            state     <= START;
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (aes_done) begin
            result <= aes_dout;
            state  <= WB;
          end
        end
        WB: begin
          if (seq_last) begin
            op_done <= 1'b1;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AES_COP_PERF_EN
  // Free-running performance counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops    <= '0;
      perf_cycles <= '0;
    end else begin
      if (op_done)       perf_ops    <= perf_ops + 32'd1;
      if (state != IDLE) perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule
